// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, branch flush and a saturating bubble counter.
// Optional WB_BYPASS_EN: forward a same-cycle WB write into the captured operands.
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       id_Instr,
  input  logic [31:0]       id_PCplus4,
  input  logic [31:0]       id_busA,
  input  logic [31:0]       id_busB,
  input  logic [CTRL_W-1:0] id_Ctrl,
  input  logic              id_ExtOp,
  input  logic              id_UsesRt,
  input  logic              ex_Flush,
  input  logic              wb_RegWr,
  input  logic [4:0]        wb_Rw,
  input  logic [31:0]       wb_busW,
  output logic              Stall,
  output logic              ex_Valid,
  output logic [CTRL_W-1:0] ex_Ctrl,
  output logic [31:0]       ex_busA,
  output logic [31:0]       ex_busB,
  output logic [31:0]       ex_Imm32,
  output logic [4:0]        ex_Rs,
  output logic [4:0]        ex_Rt,
  output logic [4:0]        ex_Rd,
  output logic [31:0]       ex_PCplus4,
  output logic [CNT_W-1:0]  BubbleCnt
);

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] imm_ext;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic sgn);
    return sgn ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

  assign id_rs   = id_Instr[25:21];
  assign id_rt   = id_Instr[20:16];
  assign id_rd   = id_Instr[15:11];
  assign imm_ext = extend_imm(id_Instr[15:0], id_ExtOp);

  // A flush must win over the stall so IF is free to fetch the branch target.
  assign Stall = ex_Valid & ex_Ctrl[1] & (ex_Rt != 5'd0) &
                 ((ex_Rt == id_rs) | (id_UsesRt & (ex_Rt == id_rt))) & ~ex_Flush;

  assign bubble = ex_Flush | Stall;

`ifdef WB_BYPASS_EN
  always_comb begin
    opa = id_busA;
    opb = id_busB;
    if (wb_RegWr && (wb_Rw != 5'd0) && (wb_Rw == id_rs)) opa = wb_busW;
    if (wb_RegWr && (wb_Rw != 5'd0) && (wb_Rw == id_rt)) opb = wb_busW;
  end
`else
  assign opa = id_busA;
  assign opb = id_busB;
`endif

  // ID -> EX boundary
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_Valid   <= 1'b0;
      ex_Ctrl    <= '0;
      ex_busA    <= '0;
      ex_busB    <= '0;
      ex_Imm32   <= '0;
      ex_Rs      <= '0;
      ex_Rt      <= '0;
      ex_Rd      <= '0;
      ex_PCplus4 <= '0;
      BubbleCnt  <= '0;
    end else begin
      ex_busA    <= opa;
      ex_busB    <= opb;
      ex_Imm32   <= imm_ext;
      ex_Rs      <= id_rs;
      ex_Rt      <= id_rt;
      ex_Rd      <= id_rd;
      ex_PCplus4 <= id_PCplus4;
      if (bubble) begin
        ex_Valid  <= 1'b0;
        ex_Ctrl   <= '0;
        BubbleCnt <= sat_inc(BubbleCnt);
      end else begin
        ex_Valid  <= 1'b1;
        ex_Ctrl   <= id_Ctrl;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Table-driven scoreboard bench for id_ex_stage (counter width reduced to exercise saturation).
module tb_id_ex_stage;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [31:0]       id_Instr, id_PCplus4, id_busA, id_busB, wb_busW;
  logic [CTRL_W-1:0] id_Ctrl;
  logic              id_ExtOp, id_UsesRt, ex_Flush, wb_RegWr;
  logic [4:0]        wb_Rw;
  logic              Stall, ex_Valid;
  logic [CTRL_W-1:0] ex_Ctrl;
  logic [31:0]       ex_busA, ex_busB, ex_Imm32, ex_PCplus4;
  logic [4:0]        ex_Rs, ex_Rt, ex_Rd;
  logic [CNT_W-1:0]  BubbleCnt;

  id_ex_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .id_Instr(id_Instr), .id_PCplus4(id_PCplus4),
    .id_busA(id_busA), .id_busB(id_busB), .id_Ctrl(id_Ctrl), .id_ExtOp(id_ExtOp),
    .id_UsesRt(id_UsesRt), .ex_Flush(ex_Flush), .wb_RegWr(wb_RegWr), .wb_Rw(wb_Rw),
    .wb_busW(wb_busW), .Stall(Stall), .ex_Valid(ex_Valid), .ex_Ctrl(ex_Ctrl),
    .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_Imm32(ex_Imm32), .ex_Rs(ex_Rs),
    .ex_Rt(ex_Rt), .ex_Rd(ex_Rd), .ex_PCplus4(ex_PCplus4), .BubbleCnt(BubbleCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [7:0]  ctrl;
    logic        ext, usesrt, flush;
    logic        wbwr;
    logic [4:0]  wbrw;
    logic [31:0] wbw, a, b;
    logic        exp_stall;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rs, rt, rd;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[17];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  logic [31:0] pc_next = 32'h0000_0400;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic vec_t mkv(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                               input logic [7:0] ctrl, input logic ext, input logic usesrt,
                               input logic flush, input logic exp_stall);
    vec_t v;
    v.rs = rs; v.rt = rt; v.imm = imm; v.ctrl = ctrl; v.ext = ext; v.usesrt = usesrt;
    v.flush = flush; v.exp_stall = exp_stall;
    v.wbwr = 1'b0; v.wbrw = 5'd0; v.wbw = 32'h0;
    v.a = 32'hA000_0000 | {27'd0, rs}; v.b = 32'hB000_0000 | {27'd0, rt};
    return v;
  endfunction

  function automatic vec_t with_wb(input vec_t v, input logic [4:0] rw, input logic [31:0] w,
                                   input logic [31:0] a, input logic [31:0] b);
    vec_t r = v;
    r.wbwr = 1'b1; r.wbrw = rw; r.wbw = w; r.a = a; r.b = b;
    return r;
  endfunction

  // Drive one ID cycle, check Stall, predict the EX contents, then compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t g;
    logic bub;
    logic [31:0] ea, eb;
    @(negedge Clk);
    id_Instr = {6'd0, v.rs, v.rt, v.imm};
    id_PCplus4 = pc_next;
    id_busA = v.a; id_busB = v.b; id_Ctrl = v.ctrl; id_ExtOp = v.ext;
    id_UsesRt = v.usesrt; ex_Flush = v.flush;
    wb_RegWr = v.wbwr; wb_Rw = v.wbrw; wb_busW = v.wbw;
    #1;
    chk({tag, " Stall"}, {31'd0, Stall}, {31'd0, v.exp_stall});
    bub = v.flush | v.exp_stall;
    ea = v.a; eb = v.b;
`ifdef WB_BYPASS_EN
    if (v.wbwr && v.wbrw != 0 && v.wbrw == v.rs) ea = v.wbw;
    if (v.wbwr && v.wbrw != 0 && v.wbrw == v.rt) eb = v.wbw;
`endif
    if (bub && !(&cnt_model)) cnt_model = cnt_model + 1'b1;
    e.valid = ~bub; e.ctrl = bub ? 8'h00 : v.ctrl;
    e.a = ea; e.b = eb; e.pc = pc_next;
    e.imm = v.ext ? {{16{v.imm[15]}}, v.imm} : {16'h0, v.imm};
    e.rs = v.rs; e.rt = v.rt; e.rd = v.imm[15:11]; e.cnt = cnt_model;
    exp_q.push_back(e);
    if (!bub) pc_next = pc_next + 32'd4;
    @(posedge Clk); #1;
    if (exp_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
    end else begin
      g = exp_q.pop_front();
      chk({tag, " ex_Valid"}, {31'd0, ex_Valid}, {31'd0, g.valid});
      chk({tag, " ex_Ctrl"}, {24'd0, ex_Ctrl}, {24'd0, g.ctrl});
      chk({tag, " BubbleCnt"}, {28'd0, BubbleCnt}, {28'd0, g.cnt});
      if (g.valid) begin
        chk({tag, " ex_busA"}, ex_busA, g.a);
        chk({tag, " ex_busB"}, ex_busB, g.b);
        chk({tag, " ex_Imm32"}, ex_Imm32, g.imm);
        chk({tag, " ex_Rs"}, {27'd0, ex_Rs}, {27'd0, g.rs});
        chk({tag, " ex_Rt"}, {27'd0, ex_Rt}, {27'd0, g.rt});
        chk({tag, " ex_Rd"}, {27'd0, ex_Rd}, {27'd0, g.rd});
        chk({tag, " ex_PCplus4"}, ex_PCplus4, g.pc);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; id_Instr = '0; id_PCplus4 = '0; id_busA = '0; id_busB = '0;
    id_Ctrl = '0; id_ExtOp = 0; id_UsesRt = 0; ex_Flush = 0; wb_RegWr = 0; wb_Rw = '0; wb_busW = '0;

    //            rs  rt   imm       ctrl   ext us fl stall
    vecs[0]  = mkv(8, 8,  16'hFFFF, 8'h01, 1, 0, 0, 0);  // addi sign-extended
    vecs[1]  = mkv(8, 8,  16'hFFFF, 8'h01, 0, 0, 0, 0);  // zero-extended
    vecs[2]  = mkv(9, 8,  16'h0004, 8'h03, 1, 0, 0, 0);  // lw $8
    vecs[3]  = mkv(8, 10, 16'h4820, 8'h01, 0, 1, 0, 1);  // add $9,$8,$10 -> stall
    vecs[4]  = mkv(8, 10, 16'h4820, 8'h01, 0, 1, 0, 0);  // re-presented
    vecs[5]  = mkv(0, 8,  16'h0000, 8'h03, 1, 0, 0, 0);  // lw $8
    vecs[6]  = mkv(3, 8,  16'h1234, 8'h01, 0, 0, 0, 0);  // rt match but not used
    vecs[7]  = mkv(0, 0,  16'h0008, 8'h03, 1, 0, 0, 0);  // lw $0
    vecs[8]  = mkv(0, 0,  16'h0000, 8'h01, 0, 1, 0, 0);  // $0 never hazards
    vecs[9]  = mkv(1, 8,  16'h0010, 8'h03, 1, 0, 0, 0);  // lw $8
    vecs[10] = mkv(2, 8,  16'h5020, 8'h01, 0, 1, 0, 1);  // rt hazard
    vecs[11] = mkv(2, 8,  16'h5020, 8'h01, 0, 1, 0, 0);
    vecs[12] = mkv(1, 8,  16'h0010, 8'h03, 1, 0, 0, 0);  // lw $8
    vecs[13] = mkv(8, 4,  16'h0000, 8'h01, 0, 0, 1, 0);  // flush beats load-use
    vecs[14] = with_wb(mkv(10, 5, 16'h0001, 8'h01, 0, 0, 0, 0), 5'd10, 32'h55, 32'h7, 32'h3);
    vecs[15] = with_wb(mkv(0, 6, 16'h0002, 8'h01, 0, 0, 0, 0), 5'd0, 32'h66, 32'h9, 32'h4);
    vecs[16] = with_wb(mkv(4, 10, 16'h0003, 8'h05, 0, 1, 0, 0), 5'd10, 32'h55, 32'h8, 32'h3);

    repeat (2) @(posedge Clk);
    #1;
    chk("rst Stall", {31'd0, Stall}, 32'd0);
    chk("rst ex_Valid", {31'd0, ex_Valid}, 32'd0);
    chk("rst ex_Ctrl", {24'd0, ex_Ctrl}, 32'd0);
    chk("rst BubbleCnt", {28'd0, BubbleCnt}, 32'd0);
    chk("rst ex_busA", ex_busA, 32'd0);
    chk("rst ex_Imm32", ex_Imm32, 32'd0);
    chk("rst ex_PCplus4", ex_PCplus4, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Reset arriving while a load-use stall is pending.
    apply(mkv(1, 8, 16'h0000, 8'h03, 1, 0, 0, 0), "rs_lw");
    @(negedge Clk);
    id_Instr = {6'd0, 5'd8, 5'd2, 16'h0}; id_UsesRt = 0; ex_Flush = 0; wb_RegWr = 0;
    #1;
    chk("rs_stall_pre", {31'd0, Stall}, 32'd1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    chk("rs_stall_post", {31'd0, Stall}, 32'd0);
    chk("rs_valid_post", {31'd0, ex_Valid}, 32'd0);
    chk("rs_cnt_post", {28'd0, BubbleCnt}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    cnt_model = '0;

    // Saturation: more flushes than the counter can hold.
    for (int i = 0; i < 20; i++) apply(mkv(3, 4, 16'h0, 8'h01, 0, 0, 1, 0), $sformatf("sat%0d", i));
    chk("sat_final", {28'd0, BubbleCnt}, 32'd15);
    apply(mkv(3, 4, 16'h0, 8'h01, 0, 0, 0, 0), "post_sat");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
